// File: rtl/parity_pkg.sv
// ---------------------------------------------------------------------------
// parity_pkg
// Definitions shared by the parity receive path and the transmit-side
// generator: the receiver state encoding, the data width and the polarity of
// the parity bit, plus a helper that computes the parity bit for a byte.
// No ports (package).
// ---------------------------------------------------------------------------
package parity_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic PARITY_EVEN = 1'b0;

  // Parity bit a transmitter attaches to a byte. For even parity, this makes
  // the total count of ones across data and parity even.
  function automatic logic parityBitFor(input logic [DATA_BITS-1:0] data);
    return (^data) ^ PARITY_EVEN;
  endfunction

endpackage

// File: rtl/parity_rx_sync.sv
// ---------------------------------------------------------------------------
// parity_rx_sync
// Two-flop synchroniser for the idle-high serial line. Both flops reset to 1,
// so that a reset never looks like a falling start edge.
// Ports:
//   i_clk   rising-edge clock
//   i_rst   synchronous, active-high reset
//   i_async asynchronous serial input
//   o_sync  synchronised copy of i_async, two cycles later
// ---------------------------------------------------------------------------
module parity_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/parity_rx.sv
// ---------------------------------------------------------------------------
// parity_rx
// Serial parity receiver. Deserialises an idle-high frame (start, 8 data bits
// LSB first, even-parity bit, stop). Checks parity and framing, and presents
// each byte with a one-cycle valid pulse.
// Parameter:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
// Ports:
//   i_clk         rising-edge clock
//   i_rst         synchronous, active-high reset
//   i_rx_in       serial line, idle high, asynchronous to i_clk
//   o_data_out    last received byte (held until next frame completes)
//   o_data_valid  one-cycle pulse per completed frame
//   o_parity_err  parity mismatch, qualified by o_data_valid
//   o_frame_err   stop bit sampled low, qualified by o_data_valid
//   o_busy        receiver is not idle
//   o_err_count   saturating error counter; present only when the macro
//                 PARITY_RX_ERRCNT_EN is defined
// ---------------------------------------------------------------------------
module parity_rx
  import parity_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_in,
  output logic [7:0] o_data_out,
  output logic       o_data_valid,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_busy
`ifdef PARITY_RX_ERRCNT_EN
  ,
  output logic [7:0] o_err_count
`endif
);

  localparam int TW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_TICK = TW'(HALF - 1);
  localparam logic [2:0]    LAST_IDX  = 3'(DATA_BITS - 1);

  logic                 w_rxs;
  logic                 w_parityMismatch;
  rx_state_t            r_state;
  logic [TW-1:0]        r_bitTimer;
  logic [2:0]           r_bitIdx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parityBit;
  logic                 r_stopBit;
  logic                 r_done;
  logic [7:0]           r_dataOut;
  logic                 r_dataValid;
  logic                 r_parityErr;
  logic                 r_frameErr;

  parity_rx_sync u_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_async(i_rx_in),
    .o_sync (w_rxs)
  );

  // Frame sequencer. START samples at mid-bit (HALF cycles in), after which
  // every bit is sampled CLKS_PER_BIT cycles later, near each bit centre.
  // Sampling the stop bit raises r_done for one cycle so the output stage can
  // publish the frame. A low stop bit parks the FSM in BREAK until the line
  // idles again, so a held-low line is not mistaken for a stream of starts.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_bitTimer  <= '0;
      r_bitIdx    <= '0;
      r_shift     <= '0;
      r_parityBit <= 1'b0;
      r_stopBit   <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_bitTimer <= '0;
          if (!w_rxs) r_state <= START;
        end
        START: begin
          if (r_bitTimer == HALF_TICK) begin
            r_bitTimer <= '0;
            r_bitIdx   <= '0;
            r_state    <= w_rxs ? IDLE : DATA;
          end else begin
            r_bitTimer <= r_bitTimer + TW'(1);
          end
        end
        DATA: begin
          if (r_bitTimer == LAST_TICK) begin
            r_bitTimer        <= '0;
            r_shift[r_bitIdx] <= w_rxs;
            if (r_bitIdx == LAST_IDX) r_state <= PARITY;
            else                      r_bitIdx <= r_bitIdx + 3'd1;
          end else begin
            r_bitTimer <= r_bitTimer + TW'(1);
          end
        end
        PARITY: begin
          if (r_bitTimer == LAST_TICK) begin
            r_bitTimer  <= '0;
            r_parityBit <= w_rxs;
            r_state     <= STOP;
          end else begin
            r_bitTimer <= r_bitTimer + TW'(1);
          end
        end
        STOP: begin
          if (r_bitTimer == LAST_TICK) begin
            r_bitTimer <= '0;
            r_stopBit  <= w_rxs;
            r_done     <= 1'b1;
            r_state    <= w_rxs ? IDLE : BREAK;
          end else begin
            r_bitTimer <= r_bitTimer + TW'(1);
          end
        end
        BREAK: begin
          if (w_rxs) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_parityMismatch = r_parityBit != parityBitFor(r_shift);

  // Output stage. Byte and flags are loaded together with the valid pulse and
  // then held until the next frame completes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dataOut   <= 8'h00;
      r_dataValid <= 1'b0;
      r_parityErr <= 1'b0;
      r_frameErr  <= 1'b0;
    end else begin
      r_dataValid <= r_done;
      if (r_done) begin
        r_dataOut   <= r_shift;
        r_parityErr <= w_parityMismatch;
        r_frameErr  <= ~r_stopBit;
      end
    end
  end

`ifdef PARITY_RX_ERRCNT_EN
  logic [7:0] r_errCount;

  // Counts frames that carry any error. Sticks at 8'hFF rather than wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_errCount <= 8'h00;
    end else if (r_done && (w_parityMismatch || !r_stopBit) && r_errCount != 8'hFF) begin
      r_errCount <= r_errCount + 8'd1;
    end
  end

  assign o_err_count = r_errCount;
`endif

  assign o_data_out   = r_dataOut;
  assign o_data_valid = r_dataValid;
  assign o_parity_err = r_parityErr;
  assign o_frame_err  = r_frameErr;
  assign o_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_parity_rx.sv
// ---------------------------------------------------------------------------
// tb_parity_rx
// Directed bench for parity_rx with CLKS_PER_BIT = 4. Frames are driven bit by
// bit on the falling edge. A monitor records every valid pulse (byte, flags
// and cycle). Each scenario task then checks the recorded pulses against
// hand-computed values. Error-counter checks exist only when
// PARITY_RX_ERRCNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_parity_rx;
  import parity_pkg::*;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxIn = 1'b1;
  logic [7:0] dataOut;
  logic       dataValid;
  logic       parityErr;
  logic       frameErr;
  logic       busy;
`ifdef PARITY_RX_ERRCNT_EN
  logic [7:0] errCountOut;
`endif

  int vecCount = 0;
  int missCount = 0;
  int cycle = 0;
  int startCycle = 0;

  logic [7:0] qData[$];
  logic       qPar[$];
  logic       qFrm[$];
  int         qCyc[$];

  parity_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx_in     (rxIn),
    .o_data_out  (dataOut),
    .o_data_valid(dataValid),
    .o_parity_err(parityErr),
    .o_frame_err (frameErr),
    .o_busy      (busy)
`ifdef PARITY_RX_ERRCNT_EN
    ,
    .o_err_count (errCountOut)
`endif
  );

  always #5 clk = ~clk;

  // Counts rising edges so latency can be measured in cycles.
  always @(posedge clk) cycle <= cycle + 1;

  // Records every valid pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (dataValid === 1'b1) begin
      qData.push_back(dataOut);
      qPar.push_back(parityErr);
      qFrm.push_back(frameErr);
      qCyc.push_back(cycle);
    end
  end

  task automatic clearQueues();
    qData.delete();
    qPar.delete();
    qFrm.delete();
    qCyc.delete();
  endtask

  task automatic driveBit(input logic b);
    rxIn = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic p, input logic s);
    startCycle = cycle;
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(d[i]);
    driveBit(p);
    driveBit(s);
    rxIn = 1'b1;
  endtask

  task automatic checkPulse(input int idx, input logic [7:0] expData,
                            input logic expPar, input logic expFrm, input string tag);
    vecCount++;
    if (qData.size() <= idx) begin
      missCount++;
      $display("[TB] FAIL %s pulse: pulses seen %0d, required more than %0d", tag, qData.size(), idx);
      return;
    end
    if (qData[idx] !== expData) begin
      missCount++;
      $display("[TB] FAIL %s data: got %h, required %h", tag, qData[idx], expData);
    end
    vecCount++;
    if (qPar[idx] !== expPar) begin
      missCount++;
      $display("[TB] FAIL %s parity_err: got %b, required %b", tag, qPar[idx], expPar);
    end
    vecCount++;
    if (qFrm[idx] !== expFrm) begin
      missCount++;
      $display("[TB] FAIL %s frame_err: got %b, required %b", tag, qFrm[idx], expFrm);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxIn = 1'b1;
    repeat (3) @(negedge clk);
    vecCount++;
    if ({dataOut, dataValid, parityErr, frameErr, busy} !== 12'h000) begin
      missCount++;
      $display("[TB] FAIL reset outputs: got data=%h v=%b p=%b f=%b busy=%b, required all zero",
               dataOut, dataValid, parityErr, frameErr, busy);
    end
`ifdef PARITY_RX_ERRCNT_EN
    vecCount++;
    if (errCountOut !== 8'h00) begin
      missCount++;
      $display("[TB] FAIL reset err_count: got %h, required 00", errCountOut);
    end
`endif
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_frame();
    int lat;
    clearQueues();
    sendFrame(8'hBD, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    vecCount++;
    if (qData.size() != 1) begin
      missCount++;
      $display("[TB] FAIL single count: got %0d pulses, required 1", qData.size());
    end
    checkPulse(0, 8'hBD, 1'b0, 1'b0, "single");
    if (qCyc.size() > 0) begin
      lat = qCyc[0] - (startCycle + 1);
      vecCount++;
      if (lat != 45) begin
        missCount++;
        $display("[TB] FAIL single latency: got %0d cycles, required 45", lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    clearQueues();
    sendFrame(8'h04, 1'b1, 1'b1);
    sendFrame(8'h64, 1'b1, 1'b1);
    sendFrame(8'hFF, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    vecCount++;
    if (qData.size() != 3) begin
      missCount++;
      $display("[TB] FAIL b2b count: got %0d pulses, required 3", qData.size());
    end
    checkPulse(0, 8'h04, 1'b0, 1'b0, "b2b0");
    checkPulse(1, 8'h64, 1'b0, 1'b0, "b2b1");
    checkPulse(2, 8'hFF, 1'b0, 1'b0, "b2b2");
  endtask

  task automatic test_parity_error();
    clearQueues();
    sendFrame(8'h04, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checkPulse(0, 8'h04, 1'b1, 1'b0, "parity");
`ifdef PARITY_RX_ERRCNT_EN
    vecCount++;
    if (errCountOut !== 8'h01) begin
      missCount++;
      $display("[TB] FAIL parity err_count: got %h, required 01", errCountOut);
    end
`endif
  endtask

  task automatic test_break();
    clearQueues();
    sendFrame(8'hFF, 1'b0, 1'b0);
    rxIn = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    checkPulse(0, 8'hFF, 1'b0, 1'b1, "break");
    vecCount++;
    if (dut.r_state !== BREAK || busy !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL break hold: got state=%0d busy=%b, required state=%0d busy=1",
               dut.r_state, busy, BREAK);
    end
    vecCount++;
    if (qData.size() != 1) begin
      missCount++;
      $display("[TB] FAIL break pulses during hold: got %0d, required 1", qData.size());
    end
`ifdef PARITY_RX_ERRCNT_EN
    vecCount++;
    if (errCountOut !== 8'h02) begin
      missCount++;
      $display("[TB] FAIL break err_count: got %h, required 02", errCountOut);
    end
`endif
    rxIn = 1'b1;
    repeat (6) @(negedge clk);
    vecCount++;
    if (busy !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL break release busy: got %b, required 0", busy);
    end
    clearQueues();
    sendFrame(8'hBD, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checkPulse(0, 8'hBD, 1'b0, 1'b0, "break_recover");
  endtask

  task automatic test_glitch();
    bit sawBusy;
    clearQueues();
    sawBusy = 1'b0;
    rxIn = 1'b0;
    @(negedge clk);
    rxIn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy === 1'b1) sawBusy = 1'b1;
    end
    vecCount++;
    if (sawBusy !== 1'b1 || busy !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL glitch busy: saw busy=%b, busy now=%b, required 1 then 0", sawBusy, busy);
    end
    repeat (60) @(negedge clk);
    vecCount++;
    if (qData.size() != 0) begin
      missCount++;
      $display("[TB] FAIL glitch pulses: got %0d, required 0", qData.size());
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] d;
    d = 8'h64;
    clearQueues();
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(d[i]);
    rxIn = d[4];
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vecCount++;
    if ({dataOut, dataValid, parityErr, frameErr, busy} !== 12'h000) begin
      missCount++;
      $display("[TB] FAIL midreset outputs: got data=%h v=%b p=%b f=%b busy=%b, required all zero",
               dataOut, dataValid, parityErr, frameErr, busy);
    end
    rst = 1'b0;
    rxIn = 1'b1;
    repeat (60) @(negedge clk);
    vecCount++;
    if (qData.size() != 0) begin
      missCount++;
      $display("[TB] FAIL midreset pulses: got %0d, required 0", qData.size());
    end
    sendFrame(8'hBD, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checkPulse(0, 8'hBD, 1'b0, 1'b0, "midreset_next");
  endtask

  // Runs every scenario in order, then prints the summary line.
  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_parity_error();
    test_break();
    test_glitch();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
